seq_add_nbit: RTL
=================

SEQ_ADD_NBIT -- requirements
Module: seq_add_nbit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8, bits added per cycle; SHALL satisfy 1 <= CHUNK <= WIDTH.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, request to begin an operation; sampled only when ready=1.
REQ-006 Port a, input, WIDTH, operand A; captured on the accept edge.
REQ-007 Port b, input, WIDTH, operand B; captured on the accept edge.
REQ-008 Port cin, input, 1, carry-in; captured on the accept edge and used only when sub=0.
REQ-009 Port sub, input, 1, mode select: 0 = A+B+cin, 1 = A-B; captured on the accept edge.
REQ-010 Port ready, output, 1, high when a new start will be accepted.
REQ-011 Port busy, output, 1, high while chunks are being processed.
REQ-012 Port done, output, 1, one-cycle pulse marking a valid result.
REQ-013 Port s, output, WIDTH, sum or difference.
REQ-014 Port cout, output, 1, carry out of bit WIDTH-1 (for sub=1, 1 means no borrow).
REQ-015 Port ovf, output, 1, two's-complement signed overflow.

Function
REQ-016 The block SHALL define NCH = WIDTH/CHUNK and implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 ready SHALL equal 1 in IDLE and DONE, and 0 in RUN; busy SHALL equal 1 only in RUN.
REQ-018 Accept: on an edge with ready=1 and start=1, the block SHALL latch a, b (inverted if sub=1), the carry seed (1 if sub=1, else cin) and sub, clear the chunk index to 0, and enter RUN.
REQ-019 Each RUN edge SHALL add one CHUNK-bit slice, LSB slice first, using the running carry, and write the result into the corresponding slice of s.
REQ-020 After slice NCH-1, the FSM SHALL enter DONE with done=1, cout = final carry, and ovf = (A[msb] == B'[msb]) && (s[msb] != A[msb]), where B' is the post-inversion operand.
REQ-021 Latency: done SHALL be high exactly NCH cycles after the accept edge, for exactly one cycle.
REQ-022 From DONE, the FSM SHALL go to IDLE on the next edge unless start=1, in which case a new operation SHALL be accepted (back-to-back issue, one operation every NCH+1 cycles).
REQ-023 start during RUN SHALL be ignored and SHALL NOT corrupt the in-flight operation or its latched operands.
REQ-024 Changes on a, b, cin or sub after the accept edge SHALL NOT affect the result.
REQ-025 s, cout and ovf SHALL hold their last values from DONE until the next accept; s slices SHALL update progressively during RUN and are valid only when done=1.
REQ-026 Wrap-around: results SHALL be modulo 2^WIDTH, with the excess reported only on cout.
REQ-027 When CHUNK == WIDTH, NCH = 1 and the block SHALL complete in a single RUN cycle.

Reset
REQ-028 rst=1 SHALL force IDLE, chunk index 0, and s=0, cout=0, ovf=0, done=0, busy=0, ready=1 on the next edge.
REQ-029 rst asserted mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over start on the same edge.

Structure
REQ-030 The FSM state encoding and the helper for NCH/index width ($clog2(NCH), minimum 1) SHALL live in the shared package seq_add_pkg.
REQ-031 The per-slice adder SHALL be a purely combinational sub-module add_chunk (parameter CHUNK; ports a, b, ci, s, co), instantiated once and reused every cycle.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-032 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> s=0x00000000, cout=1, ovf=0, done exactly 4 cycles after accept.
REQ-033 a=0x7FFFFFFF, b=0x00000001, sub=0 -> s=0x80000000, cout=0, ovf=1; a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0.
REQ-034 Start accept, then start=1 held high and a/b toggled during RUN -> exactly one done pulse, result of the original operands; back-to-back starts from DONE -> done pulses spaced 5 cycles apart.
REQ-035 rst asserted at the second RUN cycle -> no done pulse, all outputs 0 and ready=1 after the reset edge; a following start completes normally.
REQ-036 CHUNK=32 -> done 1 cycle after accept; CHUNK=1 -> done 32 cycles after accept; 1000 random operands per configuration match a reference model on s, cout and ovf.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and
// the chunk-index width helper.
package seq_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index register width for NCH chunks; never narrower than one bit.
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry slice adder, reused by the sequential
// adder on every RUN cycle.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] carry;

  assign carry[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign co = carry[CHUNK];

endmodule

// File: rtl/seq_add_nbit.sv
// Sequential WIDTH-bit adder/subtractor that processes one CHUNK-bit slice
// per clock, LSB slice first, with a ready/busy/done handshake.
module seq_add_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  import seq_add_pkg::*;

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = idx_width(NCH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic             cout_reg, ovf_reg;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_co;
  logic             accept, last_chunk, running;

  assign running    = (state_reg == ST_RUN);
  assign accept     = start && !running;
  assign last_chunk = (idx_reg == IW'(NCH - 1));

  assign ready = !running;
  assign busy  = running;
  assign done  = (state_reg == ST_DONE);
  assign cout  = cout_reg;
  assign ovf   = ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_chunk) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Select the operand slices addressed by the chunk index.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_reg == IW'(i)) begin
        chunk_a = a_reg[i*CHUNK +: CHUNK];
        chunk_b = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry_reg),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // b_reg already holds the post-inversion operand, so ovf sees B' directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= sub | cin;
      idx_reg   <= '0;
    end else if (running) begin
      carry_reg <= chunk_co;
      idx_reg   <= last_chunk ? '0 : idx_reg + IW'(1);
      if (last_chunk) begin
        cout_reg <= chunk_co;
        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (chunk_s[CHUNK-1] != a_reg[WIDTH-1]);
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    logic [CHUNK-1:0] slice_reg;

    always_ff @(posedge clk) begin
      if (rst)
        slice_reg <= '0;
      else if (running && idx_reg == IW'(gi))
        slice_reg <= chunk_s;
    end

    assign s[gi*CHUNK +: CHUNK] = slice_reg;
  end

endmodule
